// File: rtl/ste_dma_snd_ctrl_pkg.sv
// Shared definitions for the STE DMA-sound sequencer: register map, control bits, FSM states.
package ste_snd_pkg;

   // Register word indices inside the sound DMA window
   localparam logic [3:0] REG_CTRL    = 4'd0;
   localparam logic [3:0] REG_START_H = 4'd1;
   localparam logic [3:0] REG_START_M = 4'd2;
   localparam logic [3:0] REG_START_L = 4'd3;
   localparam logic [3:0] REG_CNT_H   = 4'd4;
   localparam logic [3:0] REG_CNT_M   = 4'd5;
   localparam logic [3:0] REG_CNT_L   = 4'd6;
   localparam logic [3:0] REG_END_H   = 4'd7;
   localparam logic [3:0] REG_END_M   = 4'd8;
   localparam logic [3:0] REG_END_L   = 4'd9;

   // Control register bit positions
   localparam int CTRL_PLAY = 0;
   localparam int CTRL_LOOP = 1;

   // Byte-address view used by the register byte lanes (ADDR_W must not exceed this)
   localparam int FULL_W = 24;

   typedef enum logic [1:0] {IDLE, CHECK, WAIT, LOAD} snd_state_t;

endpackage

// File: rtl/ste_snd_addr_ctr.sv
// Frame word counter with latched frame end and end-of-frame compare.
module ste_snd_addr_ctr #(
   parameter int CW = 21
) (
   input  logic          clk32,
   input  logic          reset,
   input  logic          load,
   input  logic          inc,
   input  logic [CW-1:0] start,
   input  logic [CW-1:0] end_addr,
   output logic [CW-1:0] cnt,
   output logic          at_end
);

   logic [CW-1:0] cur_end;

   // Frame begin latches start/end; inc advances one word, wrapping naturally
   always_ff @(posedge clk32 or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         cur_end <= '0;
      end else if (load) begin
         cnt     <= start;
         cur_end <= end_addr;
      end else if (inc) begin
         cnt     <= cnt + 1'b1;
      end
   end

   assign at_end = (cnt == cur_end);

endmodule

// File: rtl/ste_dma_snd_ctrl.sv
// STE DMA-sound frame sequencer: registers, fetch FSM, SLOAD_N strobe and frame interrupt.
module ste_dma_snd_ctrl
   import ste_snd_pkg::*;
#(
   parameter int ADDR_W      = 22,
   parameter int LOAD_CYCLES = 4
) (
   input  logic              clk32,
   input  logic              reset,
   input  logic              cs,
   input  logic [3:0]        a,
   input  logic              rw,
   input  logic              wr,
   input  logic [15:0]       din,
   output logic [15:0]       dout,
   input  logic              sreq,
   input  logic              slot,
   output logic [ADDR_W-2:0] addr,
   output logic              sload_n,
   output logic              frame_irq,
   output logic              active
);

   localparam int CW = ADDR_W - 1;

   snd_state_t    state, state_nx;
   logic          play, loop_en;
   logic [CW-1:0] start_q, end_q, cnt;
   logic          at_end, ld_frame, inc, clr_play, ld_last, we;
   logic [3:0]    lc;
   logic          unused_din;

   assign we         = cs & ~rw & wr;
   assign ld_last    = (lc == 4'(LOAD_CYCLES - 1));
   assign unused_din = ^din[15:8];

   // Replace one byte lane of a word address; byte bit 0 and bits >= ADDR_W drop out
   function automatic logic [CW-1:0] put_byte(input logic [CW-1:0] cur, input logic [1:0] sel,
                                              input logic [7:0] b);
      logic [FULL_W-1:0] full;
      full = FULL_W'({cur, 1'b0});
      case (sel)
         2'd0:    full[23:16] = b;
         2'd1:    full[15:8]  = b;
         default: full[7:0]   = b;
      endcase
      return full[ADDR_W-1:1];
   endfunction

   // Extract one byte lane of a word address as a byte address
   function automatic logic [7:0] get_byte(input logic [CW-1:0] cur, input logic [1:0] sel);
      logic [FULL_W-1:0] full;
      full = FULL_W'({cur, 1'b0});
      case (sel)
         2'd0:    return full[23:16];
         2'd1:    return full[15:8];
         default: return full[7:0];
      endcase
   endfunction

   ste_snd_addr_ctr #(.CW(CW)) u_ctr (
      .clk32   (clk32),
      .reset   (reset),
      .load    (ld_frame),
      .inc     (inc),
      .start   (start_q),
      .end_addr(end_q),
      .cnt     (cnt),
      .at_end  (at_end)
   );

   // CPU register writes; a control write beats the same-cycle end-of-frame play clear
   always_ff @(posedge clk32 or posedge reset) begin
      if (reset) begin
         play    <= 1'b0;
         loop_en <= 1'b0;
         start_q <= '0;
         end_q   <= '0;
      end else begin
         if (clr_play) play <= 1'b0;
         if (we) begin
            case (a)
               REG_CTRL: begin
                  play    <= din[CTRL_PLAY];
                  loop_en <= din[CTRL_LOOP];
               end
               REG_START_H: start_q <= put_byte(start_q, 2'd0, din[7:0]);
               REG_START_M: start_q <= put_byte(start_q, 2'd1, din[7:0]);
               REG_START_L: start_q <= put_byte(start_q, 2'd2, din[7:0]);
               REG_END_H:   end_q   <= put_byte(end_q,   2'd0, din[7:0]);
               REG_END_M:   end_q   <= put_byte(end_q,   2'd1, din[7:0]);
               REG_END_L:   end_q   <= put_byte(end_q,   2'd2, din[7:0]);
               default: ;
            endcase
         end
      end
   end

   // Register read mux; counter bytes come straight from the live counter
   always_comb begin
      dout = '0;
      if (cs & rw) begin
         case (a)
            REG_CTRL: begin
               dout[CTRL_PLAY] = play;
               dout[CTRL_LOOP] = loop_en;
            end
            REG_START_H: dout[7:0] = get_byte(start_q, 2'd0);
            REG_START_M: dout[7:0] = get_byte(start_q, 2'd1);
            REG_START_L: dout[7:0] = get_byte(start_q, 2'd2);
            REG_CNT_H:   dout[7:0] = get_byte(cnt, 2'd0);
            REG_CNT_M:   dout[7:0] = get_byte(cnt, 2'd1);
            REG_CNT_L:   dout[7:0] = get_byte(cnt, 2'd2);
            REG_END_H:   dout[7:0] = get_byte(end_q, 2'd0);
            REG_END_M:   dout[7:0] = get_byte(end_q, 2'd1);
            REG_END_L:   dout[7:0] = get_byte(end_q, 2'd2);
            default: ;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk32 or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Strobe length counter, runs only while in LOAD
   always_ff @(posedge clk32 or posedge reset) begin
      if (reset)              lc <= '0;
      else if (state == LOAD) lc <= lc + 1'b1;
      else                    lc <= '0;
   end

   // Fetch address is captured at fetch start so it holds through the strobe and one cycle after
   always_ff @(posedge clk32 or posedge reset) begin
      if (reset)                                  addr <= '0;
      else if (state == WAIT && state_nx == LOAD) addr <= cnt;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (play) state_nx = CHECK;
         CHECK: begin
            if (at_end) state_nx = (loop_en & play) ? CHECK : IDLE;
            else        state_nx = WAIT;
         end
         WAIT: begin
            if (!play)             state_nx = IDLE;
            else if (sreq && slot) state_nx = LOAD;
         end
         LOAD:  if (ld_last) state_nx = play ? CHECK : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output and datapath control decode
   always_comb begin
      ld_frame  = 1'b0;
      inc       = 1'b0;
      clr_play  = 1'b0;
      frame_irq = 1'b0;
      active    = 1'b0;
      sload_n   = 1'b1;
      case (state)
         IDLE:  ld_frame = play;
         CHECK: begin
            active = 1'b1;
            if (at_end) begin
               frame_irq = 1'b1;
               if (loop_en & play) ld_frame = 1'b1;
               else                clr_play = 1'b1;
            end
         end
         WAIT:  active = 1'b1;
         LOAD: begin
            active  = 1'b1;
            sload_n = 1'b0;
            inc     = ld_last;
         end
         default: ;
      endcase
   end

endmodule
